// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S DAC transmitter: holding buffer, BCLK divider, 64-slot frame serializer.
// Define I2S_TX_UNDERRUN_CNT_EN to build the saturating underrun counter.
module i2s_dac_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] leftin,
  input  logic [31:0] rightin,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        bclk,
  output logic        lrck,
  output logic        sdata,
  output logic        frame_start,
  output logic        underrun,
  output logic [15:0] underrun_cnt
);

  localparam int DW = 8;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic [5:0]    slot;
  logic [5:0]    slot_nx;
  logic [63:0]   shreg;
  logic [63:0]   hold;
  logic [63:0]   last_frame;
  logic          hold_full;
  logic          hold_full_nx;
  logic          primed;
  logic          tick;
  logic          fall;
  logic          load;
  logic          xfer;
  logic          underrun_ev;

  assign tick        = (div == DIV_LAST);
  assign fall        = tick & bclk;
  // Entering slot 1 loads the next frame; slot 0 still carries the previous right LSB.
  assign load        = fall & (slot == 6'd0);
  assign xfer        = sample_valid & sample_ready;
  assign underrun_ev = load & ~hold_full & primed;
  assign slot_nx     = slot + 6'd1;
  assign sdata       = shreg[63];

  always_comb begin
    hold_full_nx = hold_full;
    if (load) hold_full_nx = 1'b0;
    if (xfer) hold_full_nx = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div          <= '0;
      bclk         <= 1'b0;
      slot         <= '0;
      lrck         <= 1'b0;
      shreg        <= '0;
      hold         <= '0;
      last_frame   <= '0;
      hold_full    <= 1'b0;
      primed       <= 1'b0;
      sample_ready <= 1'b1;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      if (tick) begin
        div  <= '0;
        bclk <= ~bclk;
      end else begin
        div <= div + 8'd1;
      end

      if (fall) begin
        slot <= slot_nx;
        lrck <= slot_nx[5];
        if (load) begin
          frame_start <= 1'b1;
          if (hold_full) begin
            shreg      <= hold;
            last_frame <= hold;
          end else begin
            shreg    <= last_frame;
            underrun <= primed;
          end
        end else begin
          shreg <= {shreg[62:0], 1'b0};
        end
      end

      if (xfer) begin
        hold   <= {leftin, rightin};
        primed <= 1'b1;
      end

      hold_full    <= hold_full_nx;
      sample_ready <= ~hold_full_nx;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if (underrun_ev && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: doc/i2s_dac_tx.md
I2S_DAC_TX -- requirements
Module: i2s_dac_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: clock cycles per BCLK half-period; legal range 1..255.
REQ-002 clock  in  1  system clock; every register in the block is clocked on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 leftin  in  32  left-channel sample (two's complement), qualified by sample_valid.
REQ-005 rightin  in  32  right-channel sample, qualified by sample_valid.
REQ-006 sample_valid  in  1  producer has a stereo pair on leftin/rightin.
REQ-007 sample_ready  out  1  holding buffer is empty and can accept a pair.
REQ-008 bclk  out  1  codec bit clock.
REQ-009 lrck  out  1  codec word select: 0 = left, 1 = right.
REQ-010 sdata  out  1  serial data to the codec, MSB first, I2S format.
REQ-011 frame_start  out  1  one-cycle pulse on every frame load event.
REQ-012 underrun  out  1  one-cycle pulse when a frame load finds the holding buffer empty (after priming).
REQ-013 underrun_cnt  out  16  count of underrun events; behaviour set by REQ-030/031.

Function
REQ-014 A handshake transfer occurs on the clock edge where sample_valid=1 and sample_ready=1; leftin/rightin are captured into the holding buffer on that edge.
REQ-015 sample_ready = NOT hold_full, driven from a register; hold_full sets on a transfer and clears on a frame load.
REQ-016 Divider counter counts 0..CLK_DIV-1; on the edge where it equals CLK_DIV-1, the counter returns to 0 and bclk toggles.
REQ-017 BCLK period = 2*CLK_DIV clocks; frame = 64 BCLK periods = 128*CLK_DIV clocks.
REQ-018 Falling event: the edge where bclk toggles 1->0. On each falling event, slot counter (6 bits, reset 0) increments modulo 64, and sdata and lrck update on that same edge.
REQ-019 lrck = 0 for slots 0..31 and 1 for slots 32..63.
REQ-020 Shift register is 64 bits, {left,right}; sdata = its MSB.
  - On each falling event the register shifts left by 1.
  - The falling event that enters slot 1 is the frame load event instead of a shift.
  - Result: left MSB appears in slot 1, right MSB in slot 33, previous right LSB in slot 0 (one-BCLK I2S delay).
REQ-021 Frame load event, hold_full=1: load {hold_left,hold_right}, copy it to last_frame, clear hold_full, pulse frame_start.
REQ-022 Frame load event, hold_full=0: load last_frame (repeat previous pair), pulse frame_start, and pulse underrun if primed=1.
REQ-023 primed resets to 0 and sets on the first handshake transfer; before priming, loads send last_frame = 0 with no underrun.
REQ-024 Transfer and frame load on the same edge with hold_full=0: the load is treated as an underrun (REQ-022), and the incoming pair is stored with hold_full=1 for the next frame.
REQ-025 While hold_full=1, sample_ready=0; sample_valid is ignored and leftin/rightin are not sampled.
REQ-026 Latency: a pair accepted before frame load event N is transmitted in frame N, with its left MSB on sdata at slot 1.

Reset
REQ-027 While reset=1, asynchronously:
  - bclk, lrck, sdata, frame_start, underrun = 0;
  - sample_ready = 1; underrun_cnt = 0;
  - divider, slot counter, shift register, holding buffer, last_frame, hold_full, primed = 0.
REQ-028 Reset asserted mid-frame aborts the frame immediately, discards any held pair, and restarts at slot 0 with first bclk rise CLK_DIV clocks after release.
REQ-029 The block never drives a partial or glitched bclk pulse shorter than CLK_DIV clocks, except the truncation caused by reset itself.

Configuration
REQ-030 With I2S_TX_UNDERRUN_CNT_EN defined: underrun_cnt increments by 1 on each underrun pulse and saturates at 16'hFFFF.
REQ-031 Without I2S_TX_UNDERRUN_CNT_EN: underrun_cnt is constant 0 and no counter logic is synthesized; the underrun pulse is unaffected.

Verification
REQ-032 CLK_DIV=2, reset released, then pair L=32'h8000_0001, R=32'h7FFF_FFFE presented with valid=1 -> sample_ready drops for one frame; sdata in slots 1..32 = 1,0x30,1; slots 33..64(0) = 0,1x30,0; lrck rises at slot 32.
REQ-033 Continuous valid stream, CLK_DIV=1 -> exactly one transfer every 128 clocks; frame_start period 128; underrun never pulses.
REQ-034 Send one pair (L=32'hA5A5_A5A5), then hold valid=0 for 3 frames -> same pair repeats 3 times; 3 underrun pulses; underrun_cnt=3 with the macro, 0 without it.
REQ-035 No transfer after reset for 2 frames -> sdata constant 0, frame_start pulses twice, underrun never pulses.
REQ-036 Assert valid on the exact frame-load edge with hold empty -> underrun=1 that edge; the new pair appears in the following frame.
REQ-037 Assert reset at slot 40 -> all outputs 0 immediately; after release bclk first rises at clock CLK_DIV and the held pair is gone.
